// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the UART receive buffer to the system side (valid/ready).
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: frame-boundary configuration handshake, byte FIFO, error/overrun counters.
// Optional macro UART_RX_CTRL_FLUSH_EN: an accepted configuration change also empties the FIFO.
module uart_rx_ctrl #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         CNT_WIDTH    = 8,
    parameter logic [5:0] DEF_PRESCALE = 6'd8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_req,
    input  logic [5:0]                      cfg_prescale,
    input  logic                            cfg_par_en,
    input  logic                            cfg_par_typ,
    output logic                            cfg_ack,
    output logic                            cfg_err,
    output logic [5:0]                      PRESCALE,
    output logic                            PAR_EN,
    output logic                            PAR_TYP,
    output logic                            rx_enable,
    input  logic                            rx_busy,
    input  logic [DATA_WIDTH-1:0]           rx_data,
    input  logic                            rx_frame_done,
    input  logic                            rx_par_err,
    input  logic                            rx_stp_err,
    uart_rx_ctrl_if.master                  stream,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [CNT_WIDTH-1:0]            err_cnt,
    output logic [CNT_WIDTH-1:0]            ovr_cnt,
    input  logic                            cnt_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {RUN, WAIT_IDLE, APPLY, ACK} cfg_state_t;

    cfg_state_t state, state_nxt;
    logic       req_armed;
    logic       reject;
    logic       cfg_bad;
    logic       apply_ok;
    logic       flush;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    assign cfg_bad  = (cfg_prescale < 6'd4);
    assign apply_ok = (state == APPLY) && !cfg_bad;

`ifdef UART_RX_CTRL_FLUSH_EN
    assign flush = apply_ok;
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            req_armed <= 1'b1;
            reject    <= 1'b0;
            PRESCALE  <= DEF_PRESCALE;
            PAR_EN    <= 1'b0;
            PAR_TYP   <= 1'b0;
        end else begin
            state <= state_nxt;
            // A held request is consumed once; re-arm only after it is seen low.
            if (state == ACK)
                req_armed <= 1'b0;
            else if (!cfg_req)
                req_armed <= 1'b1;
            if (state == APPLY) begin
                reject <= cfg_bad;
                if (!cfg_bad) begin
                    PRESCALE <= cfg_prescale;
                    PAR_EN   <= cfg_par_en;
                    PAR_TYP  <= cfg_par_typ;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rx_enable = 1'b0;
        cfg_ack   = 1'b0;
        cfg_err   = 1'b0;
        case (state)
            RUN: begin
                rx_enable = 1'b1;
                if (cfg_req && req_armed)
                    state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!rx_busy)
                    state_nxt = APPLY;
            end
            APPLY: begin
                state_nxt = ACK;
            end
            ACK: begin
                cfg_ack   = 1'b1;
                cfg_err   = reject;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [LW-1:0]         level, level_nxt;
    logic [DATA_WIDTH-1:0] head, head_nxt;
    logic                  head_vld;
    logic                  push_req, push_ok, pop, full, ovr_inc, err_inc;

    assign pop      = head_vld & stream.out_ready;
    assign full     = (level == LW'(FIFO_DEPTH));
    assign push_req = rx_frame_done & ~rx_par_err & ~rx_stp_err;
    assign push_ok  = push_req & (~full | pop) & ~flush;
    assign ovr_inc  = push_req & full & ~pop;
    assign err_inc  = rx_frame_done & (rx_par_err | rx_stp_err);

    always_comb begin
        level_nxt  = level;
        rd_ptr_nxt = rd_ptr;
        if (push_ok && !pop)
            level_nxt = level + LW'(1);
        else if (!push_ok && pop)
            level_nxt = level - LW'(1);
        if (pop)
            rd_ptr_nxt = rd_ptr + AW'(1);
        if (flush) begin
            level_nxt  = '0;
            rd_ptr_nxt = '0;
        end
    end

    // Head is registered: a push into an (effectively) empty FIFO bypasses memory.
    always_comb begin
        head_nxt = mem[rd_ptr_nxt];
        if (push_ok && (level == (pop ? LW'(1) : LW'(0))))
            head_nxt = rx_data;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_data;
        head <= head_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (flush)
                wr_ptr <= '0;
            else if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            head_vld <= (level_nxt != '0);
        end
    end

    assign stream.out_data  = head;
    assign stream.out_valid = head_vld;
    assign fifo_level       = level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
            ovr_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
            ovr_cnt <= '0;
        end else begin
            if (err_inc)
                err_cnt <= sat_inc(err_cnt);
            if (ovr_inc)
                ovr_cnt <= sat_inc(ovr_cnt);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, scoreboard queue and corner-case sequences.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_req, cfg_par_en, cfg_par_typ;
    logic [5:0] cfg_prescale;
    logic       cfg_ack, cfg_err;
    logic [5:0] prescale;
    logic       par_en, par_typ, rx_enable;
    logic       rx_busy, rx_frame_done, rx_par_err, rx_stp_err;
    logic [7:0] rx_data;
    logic [2:0] fifo_level;
    logic [7:0] err_cnt, ovr_cnt;
    logic       cnt_clr;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    logic [7:0] sb[$];

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) stream_if ();

    uart_rx_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_req(cfg_req), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ), .rx_enable(rx_enable),
        .rx_busy(rx_busy), .rx_data(rx_data), .rx_frame_done(rx_frame_done),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
        .stream(stream_if.master),
        .fifo_level(fifo_level), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted head byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst && stream_if.out_valid && stream_if.out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
                check("pop_data", 32'(stream_if.out_data), 32'(sb.pop_front()));
        end
    end

    always @(posedge clk) begin
        if (cfg_ack)
            ack_cnt <= ack_cnt + 1;
    end

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic exp_push);
        rx_data       = d;
        rx_par_err    = p;
        rx_stp_err    = s;
        rx_frame_done = 1'b1;
        if (exp_push)
            sb.push_back(d);
        tick();
        rx_frame_done = 1'b0;
        rx_par_err    = 1'b0;
        rx_stp_err    = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input string name);
        bit got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (cfg_ack) got = 1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic drain();
        stream_if.out_ready = 1'b1;
        for (int i = 0; i < 20 && (fifo_level != 0 || stream_if.out_valid); i++)
            tick();
        stream_if.out_ready = 1'b0;
        tick();
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic       exp_push;
        logic [7:0] exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h11, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[2] = '{8'h33, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[3] = '{8'h44, 1'b0, 1'b0, 1'b1, 8'd2};
        tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'd3};
        tbl[5] = '{8'h66, 1'b0, 1'b0, 1'b1, 8'd3};

        rst = 1'b0;
        cfg_req = 0; cfg_prescale = 0; cfg_par_en = 0; cfg_par_typ = 0;
        rx_busy = 0; rx_data = 0; rx_frame_done = 0; rx_par_err = 0; rx_stp_err = 0;
        cnt_clr = 0;
        stream_if.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        check("rst_prescale", 32'(prescale), 32'd8);
        check("rst_par_en", 32'(par_en), 32'd0);
        check("rst_par_typ", 32'(par_typ), 32'd0);
        check("rst_rx_enable", 32'(rx_enable), 32'd1);
        check("rst_out_valid", 32'(stream_if.out_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
        check("rst_cfg_ack", 32'(cfg_ack), 32'd0);

        // Config request held off by a busy receiver
        rx_busy = 1'b1;
        cfg_req = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b1;
        repeat (20) tick();
        check("busy_rx_enable", 32'(rx_enable), 32'd0);
        check("busy_prescale", 32'(prescale), 32'd8);
        check("busy_par_en", 32'(par_en), 32'd0);
        check("busy_no_ack", 32'(ack_cnt), 32'd0);
        rx_busy = 1'b0;
        wait_ack("cfg_ack_seen");
        check("cfg_err_ok", 32'(cfg_err), 32'd0);
        check("cfg_prescale_16", 32'(prescale), 32'd16);
        check("cfg_par_en_1", 32'(par_en), 32'd1);
        repeat (10) tick();
        check("held_req_one_ack", 32'(ack_cnt), 32'd1);
        check("run_rx_enable", 32'(rx_enable), 32'd1);
        cfg_req = 1'b0;
        repeat (2) tick();

        // Rejected request
        cfg_req = 1'b1; cfg_prescale = 6'd3; cfg_par_en = 1'b0;
        wait_ack("rej_ack_seen");
        check("rej_cfg_err", 32'(cfg_err), 32'd1);
        check("rej_prescale", 32'(prescale), 32'd16);
        check("rej_par_en", 32'(par_en), 32'd1);
        cfg_req = 1'b0;
        repeat (2) tick();
        check("rej_ack_cnt", 32'(ack_cnt), 32'd2);

        // Vector table with the consumer always ready
        stream_if.out_ready = 1'b1;
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stp, tbl[i].exp_push);
            check("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].exp_err));
            check("tbl_ovr_cnt", 32'(ovr_cnt), 32'd0);
        end
        drain();

        // Overrun: fill four, fifth good frame is dropped
        send_frame(8'hA5, 0, 0, 1);
        send_frame(8'h3C, 0, 0, 1);
        send_frame(8'hFF, 0, 0, 1);
        send_frame(8'h01, 0, 0, 1);
        check("full_out_valid", 32'(stream_if.out_valid), 32'd1);
        check("full_head", 32'(stream_if.out_data), 32'hA5);
        send_frame(8'h77, 0, 0, 0);
        check("ovr_level", 32'(fifo_level), 32'd4);
        check("ovr_cnt_1", 32'(ovr_cnt), 32'd1);
        drain();

        // Full FIFO with push and pop in the same cycle
        send_frame(8'h10, 0, 0, 1);
        send_frame(8'h20, 0, 0, 1);
        send_frame(8'h30, 0, 0, 1);
        send_frame(8'h40, 0, 0, 1);
        rx_data = 8'h55; rx_frame_done = 1'b1; stream_if.out_ready = 1'b1;
        sb.push_back(8'h55);
        tick();
        rx_frame_done = 1'b0; stream_if.out_ready = 1'b0;
        check("pushpop_level", 32'(fifo_level), 32'd4);
        check("pushpop_ovr", 32'(ovr_cnt), 32'd1);
        drain();

        // Error counter saturation and clear priority
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_err", 32'(err_cnt), 32'd0);
        check("clr_ovr", 32'(ovr_cnt), 32'd0);
        for (int i = 0; i < 300; i++)
            send_frame(8'hC3, 0, 1, 0);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        check("sat_level", 32'(fifo_level), 32'd0);
        cnt_clr = 1'b1;
        send_frame(8'hC3, 0, 1, 0);
        cnt_clr = 1'b0;
        check("clr_prio_err", 32'(err_cnt), 32'd0);

        // Asynchronous reset with a pending request and buffered bytes
        send_frame(8'h81, 0, 0, 0);
        send_frame(8'h82, 0, 0, 0);
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        rx_busy = 1'b1; cfg_req = 1'b1; cfg_prescale = 6'd20;
        repeat (3) tick();
        check("pend_rx_enable", 32'(rx_enable), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_valid", 32'(stream_if.out_valid), 32'd0);
        check("arst_rx_enable", 32'(rx_enable), 32'd1);
        check("arst_prescale", 32'(prescale), 32'd8);
        cfg_req = 1'b0; rx_busy = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_ack", 32'(cfg_ack), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control and buffering block that sits between the UART receive FSM/datapath and the system side.
- Owns the receiver configuration registers (PRESCALE, PAR_EN, PAR_TYP) and applies changes only at a frame boundary, using a req/ack handshake.
- Buffers good received bytes in a small FIFO with a valid/ready output.
- Keeps saturating error and overrun counters.

Parameters:
DATA_WIDTH, 8, received byte width
FIFO_DEPTH, 4, buffer entries; power of 2, minimum 2
CNT_WIDTH, 8, width of each error/overrun counter
DEF_PRESCALE, 6'd8, PRESCALE value loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cfg_req  in  1  level request to load new configuration
cfg_prescale  in  6  requested oversampling prescale
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
cfg_ack  out  1  one-cycle pulse: request processed
cfg_err  out  1  one-cycle pulse with cfg_ack: request rejected
PRESCALE  out  6  applied prescale to receiver
PAR_EN  out  1  applied parity enable
PAR_TYP  out  1  applied parity type
rx_enable  out  1  receiver may leave IDLE for a new start bit
rx_busy  in  1  receiver FSM not in IDLE
rx_data  in  DATA_WIDTH  deserialized byte
rx_frame_done  in  1  one-cycle pulse at end of every frame
rx_par_err  in  1  parity error for the frame; valid with rx_frame_done
rx_stp_err  in  1  stop error for the frame; valid with rx_frame_done
out_data  out  DATA_WIDTH  FIFO head byte
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head byte
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy
err_cnt  out  CNT_WIDTH  frames with a parity or stop error
ovr_cnt  out  CNT_WIDTH  good frames dropped because the FIFO was full
cnt_clr  in  1  synchronous clear of err_cnt and ovr_cnt

Behaviour:
Reset values:
- PRESCALE=DEF_PRESCALE, PAR_EN=0, PAR_TYP=0, rx_enable=1.
- cfg_ack=0, cfg_err=0, FIFO empty, out_valid=0, fifo_level=0.
- err_cnt=0, ovr_cnt=0.
- Config FSM in RUN, req_armed=1.

Config FSM states RUN, WAIT_IDLE, APPLY, ACK:
- RUN: rx_enable=1. Go to WAIT_IDLE when cfg_req=1 and req_armed=1.
- WAIT_IDLE: rx_enable=0, so no new frame starts; a frame already in progress completes normally. Go to APPLY on the first cycle rx_busy=0.
- APPLY (1 cycle): rx_enable=0. If cfg_prescale<4, the request is rejected: registers unchanged and cfg_err is flagged. Otherwise PRESCALE, PAR_EN and PAR_TYP load from the cfg inputs on this clock edge.
- ACK (1 cycle): cfg_ack=1, cfg_err=reject flag, rx_enable=0, req_armed cleared. Then go to RUN.
- req_armed re-sets only once cfg_req is sampled 0, so a held request is processed exactly once.
- Configuration outputs never change while rx_busy=1.

FIFO push:
- On rx_frame_done with rx_par_err=0 and rx_stp_err=0.
- If the FIFO is full and no pop happens that cycle: byte dropped, ovr_cnt increments.
- If full with a simultaneous pop: push accepted, no overrun.

FIFO pop:
- On out_valid & out_ready.
- out_data and out_valid are registered. Push into an empty FIFO gives out_valid=1 on the next cycle (latency 1).
- Simultaneous push and pop on an empty FIFO is impossible, since out_valid=0.
- Pointers wrap modulo FIFO_DEPTH.

Counters:
- err_cnt increments on rx_frame_done when either error flag is 1.
- Both counters saturate at all ones.
- cnt_clr has priority over a coincident increment: result 0.

Asynchronous reset mid-operation aborts any pending config request and empties the FIFO.

Optional Feature:
UART_RX_CTRL_FLUSH_EN:
- When defined, an accepted (non-rejected) APPLY also empties the FIFO in the same cycle: level=0, out_valid=0 next cycle. This discards bytes received under the old configuration.
- When undefined, FIFO contents and pointers are preserved across configuration changes.
- A rejected request never flushes.

Test Plan:
- Reset, then check outputs -> PRESCALE=8, PAR_EN=0, rx_enable=1, out_valid=0, err_cnt=ovr_cnt=0.
- cfg_req=1 with cfg_prescale=16, cfg_par_en=1 while rx_busy=1 for 20 cycles -> rx_enable=0, PRESCALE stays 8 until rx_busy=0. Then PRESCALE=16 and PAR_EN=1, cfg_ack pulses once, and cfg_req held high gives no second ack.
- cfg_req with cfg_prescale=3 -> cfg_ack=1 and cfg_err=1 in the same cycle; PRESCALE unchanged.
- Push 0xA5, 0x3C, 0xFF, 0x01 with out_ready=0, then a 5th good frame 0x77 -> fifo_level=4, ovr_cnt=1. Then out_ready=1 pops A5, 3C, FF, 01 in order.
- FIFO full, rx_frame_done (good, 0x55) in the same cycle as a pop -> no overrun, level stays 4, and 0x55 is popped last.
- 300 frames with rx_stp_err=1 -> err_cnt saturates at 255, no FIFO push. cnt_clr coincident with a further error frame -> err_cnt=0.
